// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   At the start of every frame it takes one nibble from each of the eight
//   register values and freezes it in a snapshot buffer. It then scans the
//   digits one at a time. Each digit slot begins with a blanking gap, which
//   prevents ghosting, and is followed by the drive phase.
//
//   Optional feature macro: DISP_DIM_EN
//     When defined, the bright port exists. The digit enable is then PWM-gated
//     inside the drive phase, while the segment bus stays valid.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   scan_en     level, 1 = run continuous frames
//   nib_sel     nibble shown for every register (0 = [3:0] .. 3 = [15:12])
//   reg_0..7    register values, reg_k is shown on digit k
//   bright      PWM duty, DISP_DIM_EN only (7 = full on, 0 = 1 of 8)
//   seg         segment pattern, bit7 = a .. bit1 = g, bit0 = dp
//   dig_an      one-hot digit enable, bit k = digit k
//   cur_digit   digit currently in its slot
//   frame_done  one-cycle pulse on the last cycle of digit 7's slot
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
   parameter int DIV       = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic [1:0]  nib_sel,
   input  logic [15:0] reg_0,
   input  logic [15:0] reg_1,
   input  logic [15:0] reg_2,
   input  logic [15:0] reg_3,
   input  logic [15:0] reg_4,
   input  logic [15:0] reg_5,
   input  logic [15:0] reg_6,
   input  logic [15:0] reg_7,
`ifdef DISP_DIM_EN
   input  logic [2:0]  bright,
`endif
   output logic [7:0]  seg,
   output logic [7:0]  dig_an,
   output logic [2:0]  cur_digit,
   output logic        frame_done
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST     = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BLK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] CNT_BLK      = CW'(BLANK_CYC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      BLANK = 2'd2,
      DRIVE = 2'd3
   } state_t;

   state_t        state_r, state_nx;
   logic [CW-1:0] cnt_r, cnt_nx;
   logic [2:0]    digit_r, digit_nx;
   logic [3:0]    snap_r [8];
   logic [15:0]   reg_arr_s [8];
   logic [7:0]    seg_r, seg_nx;
   logic [7:0]    dig_an_r, dig_an_nx;
   logic          frame_done_r, frame_done_nx;
   logic          pwm_on_s;

   // Segment encoding of one hex digit (a..g, dp). The dp bit is always off.
   function automatic logic [7:0] hex7(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0:    s = 8'hFC;
         4'h1:    s = 8'h60;
         4'h2:    s = 8'hDA;
         4'h3:    s = 8'hF2;
         4'h4:    s = 8'h66;
         4'h5:    s = 8'hB6;
         4'h6:    s = 8'hBE;
         4'h7:    s = 8'hE0;
         4'h8:    s = 8'hFE;
         4'h9:    s = 8'hF6;
         4'hA:    s = 8'hEE;
         4'hB:    s = 8'h3E;
         4'hC:    s = 8'h9C;
         4'hD:    s = 8'h7A;
         4'hE:    s = 8'h9E;
         4'hF:    s = 8'h8E;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   // Return the selected nibble of a 16-bit register value.
   function automatic logic [3:0] nib_pick(input logic [15:0] v, input logic [1:0] sel);
      logic [3:0] n;
      case (sel)
         2'd0:    n = v[3:0];
         2'd1:    n = v[7:4];
         2'd2:    n = v[11:8];
         2'd3:    n = v[15:12];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

   assign reg_arr_s[0] = reg_0;
   assign reg_arr_s[1] = reg_1;
   assign reg_arr_s[2] = reg_2;
   assign reg_arr_s[3] = reg_3;
   assign reg_arr_s[4] = reg_4;
   assign reg_arr_s[5] = reg_5;
   assign reg_arr_s[6] = reg_6;
   assign reg_arr_s[7] = reg_7;

   // Next-state, slot counter and digit sequencing.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      digit_nx = digit_r;
      case (state_r)
         IDLE: begin
            if (scan_en) begin
               state_nx = LOAD;
            end else begin
               state_nx = IDLE;
            end
         end
         LOAD: begin
            digit_nx = 3'd0;
            cnt_nx   = '0;
            state_nx = BLANK;
         end
         BLANK: begin
            cnt_nx = cnt_r + CW'(1);
            if (cnt_r == CNT_BLK_LAST) begin
               state_nx = DRIVE;
            end else begin
               state_nx = BLANK;
            end
         end
         DRIVE: begin
            if (cnt_r == CNT_LAST) begin
               cnt_nx = '0;
               if (digit_r == 3'd7) begin
                  // A frame always finishes; scan_en only decides what follows it.
                  digit_nx = 3'd0;
                  state_nx = scan_en ? LOAD : IDLE;
               end else begin
                  digit_nx = digit_r + 3'd1;
                  state_nx = BLANK;
               end
            end else begin
               cnt_nx   = cnt_r + CW'(1);
               state_nx = DRIVE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            digit_nx = 3'd0;
         end
      endcase
   end

`ifdef DISP_DIM_EN
   // PWM gate: position inside the 8-cycle window, counted from the start of the drive phase.
   always_comb begin
      pwm_on_s = 1'b0;
      if (3'(cnt_nx - CNT_BLK) <= bright) begin
         pwm_on_s = 1'b1;
      end else begin
         pwm_on_s = 1'b0;
      end
   end
`else
   assign pwm_on_s = 1'b1;
`endif

   // Output values for the state being entered, so the registered outputs line up with it.
   always_comb begin
      seg_nx        = 8'h00;
      dig_an_nx     = 8'h00;
      frame_done_nx = 1'b0;
      if (state_nx == DRIVE) begin
         seg_nx        = hex7(snap_r[digit_nx]);
         dig_an_nx     = pwm_on_s ? (8'h01 << digit_nx) : 8'h00;
         frame_done_nx = (cnt_nx == CNT_LAST) && (digit_nx == 3'd7);
      end else begin
         seg_nx        = 8'h00;
         dig_an_nx     = 8'h00;
         frame_done_nx = 1'b0;
      end
   end

   // State, counter, digit and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         digit_r      <= 3'd0;
         seg_r        <= 8'h00;
         dig_an_r     <= 8'h00;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nx;
         cnt_r        <= cnt_nx;
         digit_r      <= digit_nx;
         seg_r        <= seg_nx;
         dig_an_r     <= dig_an_nx;
         frame_done_r <= frame_done_nx;
      end
   end

   // Snapshot buffer. It is written only in LOAD, so register changes in mid-frame stay invisible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) snap_r[k] <= 4'h0;
      end else if (state_r == LOAD) begin
         for (int k = 0; k < 8; k++) snap_r[k] <= nib_pick(reg_arr_s[k], nib_sel);
      end
   end

   assign seg        = seg_r;
   assign dig_an     = dig_an_r;
   assign cur_digit  = digit_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV=8, BLANK_CYC=2.
// Each frame is 65 cycles: one LOAD cycle, then 8 slots of 2 blank and 6 drive cycles.
module tb_disp_scan_ctrl;

   localparam logic [7:0] HEX [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                       8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   logic        clk;
   logic        rst_n;
   logic        scan_en;
   logic [1:0]  nib_sel;
   logic [15:0] regs [8];
   logic [2:0]  bright_v;
   logic [7:0]  seg;
   logic [7:0]  dig_an;
   logic [2:0]  cur_digit;
   logic        frame_done;

   logic [3:0]  exp_nib [8];
   int          n_chk;
   int          n_pass;

   disp_scan_ctrl #(.DIV(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .nib_sel    (nib_sel),
      .reg_0      (regs[0]),
      .reg_1      (regs[1]),
      .reg_2      (regs[2]),
      .reg_3      (regs[3]),
      .reg_4      (regs[4]),
      .reg_5      (regs[5]),
      .reg_6      (regs[6]),
      .reg_7      (regs[7]),
`ifdef DISP_DIM_EN
      .bright     (bright_v),
`endif
      .seg        (seg),
      .dig_an     (dig_an),
      .cur_digit  (cur_digit),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".seg"}, 32'(seg), 32'h0);
      chk({tag, ".dig"}, 32'(dig_an), 32'h0);
      chk({tag, ".fd"}, 32'(frame_done), 32'h0);
      chk({tag, ".cd"}, 32'(cur_digit), 32'h0);
   endtask

   // Walk n_cyc cycles starting at the LOAD cycle and compare against the frame model.
   // act_code 1 clears reg_0 and act_code 2 drops scan_en, both after the check at cycle act_idx.
   task automatic frame_check(input string tag, input int n_cyc, input int act_idx, input int act_code);
      int pulses;
      int s;
      int c;
      logic [7:0] e_seg;
      logic [7:0] e_dig;
      logic       e_fd;
      pulses = 0;
      for (int i = 0; i < n_cyc; i++) begin
         @(negedge clk);
         s = (i == 0) ? 0 : (i - 1) / 8;
         c = (i == 0) ? 0 : (i - 1) % 8;
         e_seg = 8'h00;
         e_dig = 8'h00;
         e_fd  = 1'b0;
         if (i > 0 && c >= 2) begin
            e_seg = HEX[exp_nib[s]];
            e_dig = ((c - 2) <= int'(bright_v)) ? (8'h01 << s) : 8'h00;
            e_fd  = (s == 7 && c == 7);
         end
         chk($sformatf("%s.seg[%0d]", tag, i), 32'(seg), 32'(e_seg));
         chk($sformatf("%s.dig[%0d]", tag, i), 32'(dig_an), 32'(e_dig));
         chk($sformatf("%s.fd[%0d]", tag, i), 32'(frame_done), 32'(e_fd));
         chk($sformatf("%s.cd[%0d]", tag, i), 32'(cur_digit), 32'(s));
         if (frame_done === 1'b1) pulses++;
         if (i == act_idx) begin
            case (act_code)
               1:       regs[0] = 16'h0000;
               2:       scan_en = 1'b0;
               default: ;
            endcase
         end
      end
      if (n_cyc == 65) chk({tag, ".pulses"}, 32'(pulses), 32'd1);
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      scan_en  = 1'b0;
      nib_sel  = 2'd0;
      bright_v = 3'd7;
      for (int k = 0; k < 8; k++) begin
         regs[k]    = 16'h0000;
         exp_nib[k] = 4'h0;
      end

      // 1: reset, then idle with scan_en low.
      repeat (3) @(negedge clk);
      chk_zero("t1.rst");
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk_zero($sformatf("t1.idle[%0d]", i));
      end

      // 2: reg_k = k, nibble 0, continuous scan.
      for (int k = 0; k < 8; k++) begin
         regs[k]    = 16'(k);
         exp_nib[k] = 4'(k);
      end
      scan_en = 1'b1;
      frame_check("t2", 65, -1, 0);

      // 3: nibble 3 and reg_0 = A123. Clearing reg_0 in mid-frame waits for the next frame.
      nib_sel = 2'd3;
      regs[0] = 16'hA123;
      for (int k = 0; k < 8; k++) exp_nib[k] = 4'h0;
      exp_nib[0] = 4'hA;
      frame_check("t3", 65, 20, 1);

      // 4: next frame shows the cleared reg_0. scan_en drops during digit 3 drive and the frame still completes.
      exp_nib[0] = 4'h0;
      frame_check("t4", 65, 29, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_zero($sformatf("t4.idle[%0d]", i));
      end

      // 5: digits 8..F from nibble 1. Reset is asserted in the middle of digit 5 drive.
      nib_sel = 2'd1;
      for (int k = 0; k < 8; k++) begin
         regs[k]    = 16'(k + 8) << 4;
         exp_nib[k] = 4'(k + 8);
      end
      scan_en = 1'b1;
      frame_check("t5", 45, -1, 0);
      chk("t5.pre.dig", 32'(dig_an), 32'h20);
      #2 rst_n = 1'b0;
      #1 chk_zero("t5.async");
      repeat (2) begin
         @(negedge clk);
         chk_zero("t5.held");
      end
      rst_n = 1'b1;
      frame_check("t5r", 65, -1, 0);

`ifdef DISP_DIM_EN
      // 6: PWM dimming. The seg bus stays constant while dig_an is gated.
      bright_v = 3'd3;
      frame_check("t6a", 65, -1, 0);
      bright_v = 3'd7;
      frame_check("t6b", 65, -1, 0);
`endif

      scan_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
